// File: rtl/riscv_intr_pkg.sv
// Shared trap-sequencer definitions: FSM state encoding and the machine-mode
// CSR addresses used by both the CSR file and the interrupt controller.
package riscv_intr_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARMED   = 3'd1,
      TAKE    = 3'd2,
      HANDLER = 3'd3,
      RETURN  = 3'd4
   } intr_state_t;

   localparam logic [11:0] CSR_ADDR_MIE   = 12'h304;
   localparam logic [11:0] CSR_ADDR_MTVEC = 12'h305;
   localparam logic [11:0] CSR_ADDR_MEPC  = 12'h341;

endpackage

// File: rtl/irq_sync_edge.sv
// Single-bit synchronizer for an asynchronous IRQ line followed by a
// rising-edge detector that emits a one-cycle pulse per synchronized 0->1.
module irq_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic irq,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt/trap sequencer: latches edge-triggered pending bits, waits for an
// instruction boundary, redirects to MTVEC, and returns to MEPC on MRET.
module intr_ctrl
   import riscv_intr_pkg::*;
#(
   parameter  int N_SRC       = 4,
   parameter  int SYNC_STAGES = 2,
   localparam int CW          = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_SRC-1:0] irq,
   input  logic             csr_mie,
   input  logic [31:0]      csr_mtvec,
   input  logic [31:0]      csr_mepc,
   input  logic [31:0]      pc,
   input  logic             instr_boundary,
   input  logic             mret,
   output logic             int_taken,
   output logic             pc_override,
   output logic [31:0]      trap_pc,
   output logic [CW-1:0]    int_cause,
   output logic             in_handler,
   output logic [N_SRC-1:0] pending
);

   intr_state_t      state_q;
   intr_state_t      state_d;
   logic [N_SRC-1:0] rise_vec;
   logic [N_SRC-1:0] clr_mask;
   logic [CW-1:0]    winner;
   logic [31:0]      trap_hold_q;
   logic             unused_pc;

   // The CSR block captures the PC itself; it is only observed here.
   assign unused_pc = ^pc;

   for (genvar i = 0; i < N_SRC; i++) begin : g_sync
      irq_sync_edge #(
         .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
         .clk  (clk),
         .rst_n(rst_n),
         .irq  (irq[i]),
         .rise (rise_vec[i])
      );
   end

   always_comb begin
      winner = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (pending[i]) begin
            winner = CW'(i);
         end
      end
   end

   assign clr_mask = (state_q == TAKE) ? (N_SRC'(1) << int_cause) : '0;

   // A fresh edge arriving in the TAKE cycle overrides the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~clr_mask) | rise_vec;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         int_cause <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ARMED && state_d == TAKE) begin
            int_cause <= winner;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (|pending && csr_mie) begin
               state_d = ARMED;
            end
         end
         ARMED: begin
            if (!csr_mie || pending == '0) begin
               state_d = IDLE;
            end else if (instr_boundary) begin
               state_d = TAKE;
            end
         end
         TAKE: begin
            state_d = HANDLER;
         end
         HANDLER: begin
            if (instr_boundary && mret) begin
               state_d = RETURN;
            end
         end
         RETURN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign int_taken   = (state_q == TAKE);
   assign pc_override = (state_q == TAKE) || (state_q == RETURN);
   assign in_handler  = (state_q == TAKE) || (state_q == HANDLER) || (state_q == RETURN);

   always_comb begin
      trap_pc = trap_hold_q;
      if (state_q == TAKE) begin
         trap_pc = csr_mtvec;
      end else if (state_q == RETURN) begin
         trap_pc = csr_mepc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trap_hold_q <= '0;
      end else if (pc_override) begin
         trap_hold_q <= trap_pc;
      end
   end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl with a scoreboard of expected PC redirects.
module tb_intr_ctrl;

   localparam int N_SRC       = 4;
   localparam int SYNC_STAGES = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  irq;
   logic        csr_mie;
   logic [31:0] csr_mtvec;
   logic [31:0] csr_mepc;
   logic [31:0] pc;
   logic        instr_boundary;
   logic        mret;
   logic        int_taken;
   logic        pc_override;
   logic [31:0] trap_pc;
   logic [1:0]  int_cause;
   logic        in_handler;
   logic [3:0]  pending;

   intr_ctrl #(
      .N_SRC(N_SRC),
      .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .irq           (irq),
      .csr_mie       (csr_mie),
      .csr_mtvec     (csr_mtvec),
      .csr_mepc      (csr_mepc),
      .pc            (pc),
      .instr_boundary(instr_boundary),
      .mret          (mret),
      .int_taken     (int_taken),
      .pc_override   (pc_override),
      .trap_pc       (trap_pc),
      .int_cause     (int_cause),
      .in_handler    (in_handler),
      .pending       (pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        is_take;
      logic [31:0] target;
      logic [1:0]  cause;
   } ev_t;

   ev_t exp_q[$];
   int  tests = 0;
   int  fails = 0;
   int  takes = 0;
   int  takes_before;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Advance n cycles; every redirect the DUT makes is matched against the scoreboard.
   task automatic cyc(input int n);
      ev_t e;
      repeat (n) begin
         @(posedge clk);
         #1;
         if (pc_override) begin
            if (exp_q.size() == 0) begin
               check("unexpected_override", 32'(trap_pc), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("is_take", 32'(int_taken), 32'(e.is_take));
               check("trap_pc", trap_pc, e.target);
               if (e.is_take) begin
                  takes++;
                  check("int_cause", 32'(int_cause), 32'(e.cause));
               end
            end
         end
      end
   endtask

   task automatic wait_empty(input string tag, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         cyc(1);
         n++;
      end
      check({"drain_", tag}, 32'(exp_q.size()), 0);
      exp_q.delete();
   endtask

   task automatic push(input logic is_take, input logic [31:0] target, input logic [1:0] cause);
      ev_t e;
      e.is_take = is_take;
      e.target  = target;
      e.cause   = cause;
      exp_q.push_back(e);
   endtask

   task automatic expect_take(input logic [1:0] cause, input logic [31:0] vec);
      csr_mtvec = vec;
      push(1'b1, vec, cause);
      wait_empty("take", 20);
   endtask

   task automatic expect_ret(input logic [31:0] epc);
      csr_mepc = epc;
      push(1'b0, epc, 2'd0);
      mret = 1'b1;
      wait_empty("return", 20);
      mret = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b0;
      irq            = 4'b0000;
      csr_mie        = 1'b0;
      csr_mtvec      = 32'h0;
      csr_mepc       = 32'h0;
      pc             = 32'h0000_1000;
      instr_boundary = 1'b1;
      mret           = 1'b0;

      // Reset values
      #1;
      check("rst_int_taken", 32'(int_taken), 0);
      check("rst_pc_override", 32'(pc_override), 0);
      check("rst_trap_pc", trap_pc, 0);
      check("rst_pending", 32'(pending), 0);
      check("rst_in_handler", 32'(in_handler), 0);
      cyc(2);
      rst_n = 1'b1;
      cyc(2);

      // Basic take and return
      csr_mie   = 1'b1;
      csr_mtvec = 32'h0000_0100;
      irq[2]    = 1'b1;
      cyc(2);
      check("basic_pending_early", 32'(pending), 0);
      cyc(1);
      check("basic_pending_set", 32'(pending), 'h4);
      expect_take(2'd2, 32'h0000_0100);
      check("basic_in_handler_take", 32'(in_handler), 1);
      cyc(1);
      check("basic_pending_clr", 32'(pending), 0);
      check("basic_handler_no_ovr", 32'(pc_override), 0);
      expect_ret(32'h0000_0040);
      check("basic_in_handler_ret", 32'(in_handler), 1);
      cyc(1);
      check("basic_in_handler_fall", 32'(in_handler), 0);
      check("basic_trap_pc_hold", trap_pc, 32'h0000_0040);

      // Level held high: no retrigger
      takes_before = takes;
      cyc(50);
      check("held_single_take", 32'(takes), 32'(takes_before));
      irq = 4'b0000;
      cyc(4);

      // Priority and no nesting
      irq = 4'b1010;
      expect_take(2'd1, 32'h0000_0200);
      irq = 4'b1011;
      cyc(5);
      check("prio_pending_nested", 32'(pending), 'h9);
      check("prio_still_handler", 32'(in_handler), 1);
      expect_ret(32'h0000_0044);
      expect_take(2'd0, 32'h0000_0300);
      expect_ret(32'h0000_0048);
      expect_take(2'd3, 32'h0000_0304);
      expect_ret(32'h0000_004C);
      irq = 4'b0000;
      cyc(4);
      check("prio_pending_empty", 32'(pending), 0);

      // MIE gating
      csr_mie = 1'b0;
      irq[0]  = 1'b1;
      cyc(24);
      check("mie_pending_held", 32'(pending), 'h1);
      check("mie_idle", 32'(in_handler), 0);
      irq     = 4'b0000;
      csr_mie = 1'b1;
      expect_take(2'd0, 32'h0000_0500);
      expect_ret(32'h0000_0050);
      cyc(2);

      // Boundary wait, then MIE drop with pending retained
      instr_boundary = 1'b0;
      irq[3]         = 1'b1;
      cyc(9);
      check("armed_no_override", 32'(pc_override), 0);
      check("armed_pending", 32'(pending), 'h8);
      csr_mie = 1'b0;
      cyc(2);
      check("mie_drop_pending", 32'(pending), 'h8);
      check("mie_drop_idle", 32'(in_handler), 0);
      csr_mie        = 1'b1;
      instr_boundary = 1'b1;
      expect_take(2'd3, 32'h0000_0600);
      instr_boundary = 1'b0;
      mret           = 1'b1;
      cyc(3);
      check("mret_no_boundary", 32'(in_handler), 1);
      mret           = 1'b0;
      instr_boundary = 1'b1;
      expect_ret(32'h0000_0054);
      irq = 4'b0000;
      cyc(4);

      // New edge lands in the TAKE cycle of the same source
      csr_mtvec = 32'h0000_0700;
      push(1'b1, 32'h0000_0700, 2'd2);
      irq[2] = 1'b1;
      cyc(1);
      irq[2] = 1'b0;
      cyc(2);
      irq[2] = 1'b1;
      wait_empty("same_cycle_take", 10);
      cyc(1);
      check("set_wins_pending", 32'(pending), 'h4);
      expect_ret(32'h0000_0058);
      expect_take(2'd2, 32'h0000_0704);
      expect_ret(32'h0000_005C);
      irq = 4'b0000;
      cyc(4);

      // Stray MRET outside a handler
      mret = 1'b1;
      cyc(3);
      check("stray_mret_no_ovr", 32'(pc_override), 0);
      check("stray_mret_idle", 32'(in_handler), 0);
      mret = 1'b0;

      // Reset in the middle of a handler
      irq = 4'b1000;
      expect_take(2'd3, 32'h0000_0800);
      irq = 4'b1110;
      cyc(5);
      check("pre_rst_pending", 32'(pending), 'h6);
      rst_n = 1'b0;
      irq   = 4'b0000;
      #1;
      check("midrst_int_taken", 32'(int_taken), 0);
      check("midrst_pc_override", 32'(pc_override), 0);
      check("midrst_trap_pc", trap_pc, 0);
      check("midrst_int_cause", 32'(int_cause), 0);
      check("midrst_in_handler", 32'(in_handler), 0);
      check("midrst_pending", 32'(pending), 0);
      cyc(2);
      rst_n        = 1'b1;
      takes_before = takes;
      cyc(30);
      check("post_rst_no_take", 32'(takes), 32'(takes_before));
      check("post_rst_pending", 32'(pending), 0);

      check("queue_drained", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt/trap sequencer on the opposite side of the CSR trap interface: consumes CSR_MIE, CSR_MTVEC and CSR_MEPC, and produces the INT_TAKEN pulse that makes the CSR capture MEPC.
- Synchronizes and edge-detects external interrupt lines, latches pending bits and prioritizes them.
- Waits for a core instruction boundary, then redirects the PC to MTVEC. Redirects to MEPC on MRET.
- Sits between the external IRQ pins and the core's PC-select mux. No nesting.

Parameters:
- N_SRC, 4, number of external interrupt sources (1..16).
- SYNC_STAGES, 2, flops in each IRQ synchronizer chain (≥2).

Ports:
- CLK  in  1  core clock
- RST_N  in  1  asynchronous active-low reset
- IRQ  in  N_SRC  asynchronous external interrupt lines; rising-edge sensitive
- CSR_MIE  in  1  global interrupt enable from CSR
- CSR_MTVEC  in  32  trap handler address
- CSR_MEPC  in  32  return address
- PC  in  32  address of next instruction at boundary (informational; CSR captures it)
- INSTR_BOUNDARY  in  1  core is between instructions this cycle; redirect may be accepted
- MRET  in  1  core retiring mret this cycle (qualified by INSTR_BOUNDARY)
- INT_TAKEN  out  1  one-cycle pulse to CSR; CSR latches PC into MEPC
- PC_OVERRIDE  out  1  core loads TRAP_PC instead of its next PC this cycle
- TRAP_PC  out  32  redirect target
- INT_CAUSE  out  clog2(N_SRC) (min 1)  index of source being serviced
- IN_HANDLER  out  1  high from the TAKE cycle until the RETURN cycle inclusive
- PENDING  out  N_SRC  latched pending bits

Behaviour:
- Reset (async, RST_N=0): all sync flops, edge registers and PENDING = 0. State = IDLE. INT_TAKEN = PC_OVERRIDE = 0, TRAP_PC = 0, INT_CAUSE = 0, IN_HANDLER = 0.
- Reset mid-handler discards all state, including pending bits.
- Sync/edge: IRQ[i] passes through SYNC_STAGES flops. A 0→1 on the synchronized output sets PENDING[i] on the next edge.
- IRQ-rise-to-PENDING latency = SYNC_STAGES+1 cycles (3 at default).
- Level held high does not re-trigger.
- Priority: lowest index wins. The winner is computed combinationally from PENDING.
- FSM states: IDLE, ARMED, TAKE, HANDLER, RETURN.
- IDLE → ARMED when |PENDING and CSR_MIE.
- ARMED → IDLE if CSR_MIE=0 or PENDING=0. Pending bits are retained.
- ARMED → TAKE when INSTR_BOUNDARY=1. INT_CAUSE latches the winner at this transition.
- TAKE, exactly 1 cycle:
  - INT_TAKEN=1, PC_OVERRIDE=1, TRAP_PC=CSR_MTVEC.
  - PENDING[INT_CAUSE] cleared.
  - Next state HANDLER.
- HANDLER → RETURN on INSTR_BOUNDARY & MRET. New pending bits accumulate but are not taken (no nesting, regardless of CSR_MIE).
- RETURN, exactly 1 cycle: PC_OVERRIDE=1, TRAP_PC=CSR_MEPC. Next state IDLE.
- If pending and MIE are still valid, the next interrupt may re-arm one cycle after RETURN.
- Outside TAKE/RETURN: PC_OVERRIDE=0, INT_TAKEN=0, TRAP_PC holds its last value.
- Simultaneous set and clear of the same PENDING bit in the TAKE cycle: set wins and the bit stays 1, so a second edge is not lost.
- MRET while not in HANDLER is ignored: no override, no state change.
- MRET without INSTR_BOUNDARY is ignored in every state.
- CSR_MTVEC and CSR_MEPC are sampled combinationally in their output cycle only; no internal copy.
- INT_TAKEN and PC_OVERRIDE are registered outputs; decode them from the state register.

Decomposition:
- Shared package riscv_intr_pkg holds:
  - typedef enum intr_state_t {IDLE, ARMED, TAKE, HANDLER, RETURN};
  - CSR address constants MIE 12'h304, MTVEC 12'h305, MEPC 12'h341, so the CSR block and this block share one definition.
- One sub-module: irq_sync_edge (parameter SYNC_STAGES; single-bit synchronizer plus rising-edge pulse). Instantiated N_SRC times via generate.

Test Plan:
- Reset: assert RST_N=0 mid-HANDLER with PENDING=4'b0110 → same cycle, all outputs 0, state IDLE; after release, no INT_TAKEN without new edges.
- Basic take/return:
  - Stimulus: CSR_MIE=1, CSR_MTVEC=32'h0000_0100, IRQ[2] rises, INSTR_BOUNDARY held 1.
  - Response: PENDING[2] set 3 cycles later; INT_TAKEN and PC_OVERRIDE pulse 1 cycle with TRAP_PC=32'h100, INT_CAUSE=2; PENDING[2]=0.
  - Then MRET&INSTR_BOUNDARY with CSR_MEPC=32'h0000_0040 → PC_OVERRIDE 1 cycle with TRAP_PC=32'h40, IN_HANDLER falls after it.
- Priority and no nesting:
  - Stimulus: IRQ[3] and IRQ[1] rise together.
  - Response: take cause 1. IRQ[0] rising during HANDLER only sets PENDING[0].
  - After RETURN: cause 0 is taken next, then cause 3.
- MIE gating: PENDING[0]=1, CSR_MIE=0 for 20 cycles → stays in IDLE, no INT_TAKEN. Setting CSR_MIE=1 → TAKE at the next boundary.
- Boundary wait and MIE drop: ARMED with INSTR_BOUNDARY=0 for 5 cycles → no override. CSR_MIE then drops → IDLE with PENDING retained.
- Edge cases:
  - A new IRQ[2] edge reaches the pending-set point in the same cycle as TAKE of cause 2 → PENDING[2] remains 1 and is serviced again.
  - A stray MRET in IDLE → no PC_OVERRIDE.
  - IRQ held high for 50 cycles → exactly one take.
